// File: rtl/mux_2to1.sv
// Parameterised 2-to-1 selector: combinational y built from per-bit cells,
// plus a registered copy of y/sel and select-activity monitoring for debug.

module mux_2to1_bit (
    input  logic sel,
    input  logic i0,
    input  logic i1,
    output logic y
);
    // An unknown select propagates as X rather than being masked by equal inputs.
    always_comb begin
        y = 1'bx;
        case (sel)
            1'b0:    y = i0;
            1'b1:    y = i1;
            default: y = 1'bx;
        endcase
    end
endmodule

module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_toggle_cnt,
    output logic             sel_unknown
);
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            mux_2to1_bit u_bit (
                .sel (sel),
                .i0  (i0[b]),
                .i1  (i1[b]),
                .y   (y[b])
            );
        end
    endgenerate

    // Counter holds at all-ones; a post-reset sel=1 counts because sel_q resets to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q            <= '0;
            sel_q          <= 1'b0;
            sel_toggle_cnt <= '0;
        end else begin
            y_q   <= y;
            sel_q <= sel;
            if ((sel != sel_q) && (sel_toggle_cnt != {CNT_W{1'b1}}))
                sel_toggle_cnt <= sel_toggle_cnt + 1'b1;
        end
    end

`ifdef SYNTHESIS
    assign sel_unknown = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (!rst_n)
            sel_unknown <= 1'b0;
        else if ($isunknown(sel))
            sel_unknown <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: table-driven combinational vectors, then clocked
// sequences checked through an expected-result queue.

module tb_mux_2to1;
    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic       sel;
    logic [7:0] i0, i1;

    logic [7:0] y8, yq8;
    logic       selq8, su8;
    logic [7:0] cnt8;
    logic       y1, yq1, selq1, su1;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk;

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i0(i0[0]), .i1(i1[0]), .sel(sel),
        .y(y1), .y_q(yq1), .sel_q(selq1), .sel_toggle_cnt(cnt1), .sel_unknown(su1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .sel(sel),
        .y(y8), .y_q(yq8), .sel_q(selq8), .sel_toggle_cnt(cnt8), .sel_unknown(su8)
    );

    typedef struct {
        logic       w8;
        logic       sel;
        logic [7:0] i0;
        logic [7:0] i1;
        logic [7:0] y;
    } vec_t;

    typedef struct {
        logic [7:0] yq;
        logic       sq;
        logic [7:0] cnt;
        logic       su;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clocked transaction: drive at negedge, predict, compare after the edge.
    task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic r);
        exp_t e;
        logic xs;
        @(negedge clk);
        sel = s; i0 = a; i1 = b; rst_n = r;
        xs = $isunknown(s);
        #1;
        if (xs) chk("y_x", {7'd0, $isunknown(y8)}, 8'd1);
        else    chk("y_comb", y8, s ? b : a);
        if (!r) begin
            m.yq = '0; m.sq = 1'b0; m.cnt = '0; m.su = 1'b0;
        end else begin
            m.yq = xs ? 8'hxx : (s ? b : a);
            if (((s != m.sq) === 1'b1) && m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
            m.sq = s;
            m.su = m.su | xs;
        end
        exp_q.push_back(m);
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            chk("y_q", yq8, e.yq);
            chk("sel_q", {7'd0, selq8}, {7'd0, e.sq});
            chk("cnt", cnt8, e.cnt);
            chk("sel_unknown", {7'd0, su8}, {7'd0, e.su});
        end
    endtask

    initial begin
        vec_t tbl[10];
        logic sx;
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h01};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h01};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h01};
        tbl[7] = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h01};
        tbl[8] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5};
        tbl[9] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'h3C};

        m = '{8'h00, 1'b0, 8'h00, 1'b0};
        rst_n = 1'b0; sel = 1'b0; i0 = '0; i1 = '0;

        // Clock stopped: y must follow inputs purely combinationally.
        for (int k = 0; k < 10; k++) begin
            sel = tbl[k].sel; i0 = tbl[k].i0; i1 = tbl[k].i1;
            #10;
            if (tbl[k].w8) chk($sformatf("vec%0d_y8", k), y8, tbl[k].y);
            else           chk($sformatf("vec%0d_y1", k), {7'd0, y1}, tbl[k].y);
        end

        clk_en = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("rst_yq", yq8, 8'h00);
        chk("rst_cnt", cnt8, 8'h00);
        chk("rst_yq_w1", {7'd0, yq1}, 8'h00);
        chk("rst_cnt_w1", cnt1, 8'h00);
        chk("rst_su_w1", {6'd0, selq1, su1}, 8'h00);
        drive(1'b1, 8'h00, 8'h01, 1'b1);
        chk("first_yq", yq8, 8'h01);
        chk("first_cnt", cnt8, 8'd1);

        // Toggle every edge past saturation.
        for (int k = 0; k < 300; k++)
            drive(k[0], 8'h55, 8'hAA, 1'b1);
        chk("sat_cnt", cnt8, 8'd255);

        drive(1'b0, 8'h00, 8'h01, 1'b0);
        for (int k = 0; k < 17; k++)
            drive(~k[0], 8'h00, 8'h01, 1'b1);
        chk("mid_cnt17", cnt8, 8'd17);
        chk("mid_yq1", yq8, 8'h01);
        drive(1'b1, 8'h00, 8'h01, 1'b0);
        chk("mid_rst_cnt", cnt8, 8'd0);
        chk("mid_rst_yq", yq8, 8'h00);
        chk("mid_rst_y", y8, 8'h01);

        // Unknown select for one edge; sticky flag holds until reset.
        sx = 1'bx;
        drive(sx, 8'h0F, 8'hF0, 1'b1);
        drive(1'b0, 8'h0F, 8'hF0, 1'b1);
        drive(1'b1, 8'h0F, 8'hF0, 1'b1);
        drive(1'b0, 8'h0F, 8'hF0, 1'b0);
        chk("su_cleared", {7'd0, su8}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
